conv3x3_rgb_mac: RTL



---
 rtl/cnn_pkg.sv | 35 +++
 rtl/conv3x3_rgb_mac_channel.sv | 63 ++++++
 rtl/conv3x3_rgb_mac.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : cnn_pkg
//  Description: Shared constants and state encoding for the 3x3 RGB
//               convolution MAC: accumulator width, tap count, RGB888
//               channel slices and the controller state type.
//  Revision   : 1.0  initial release
// ============================================================================
package cnn_pkg;

    localparam int c_ACC_W = 22;   // signed accumulator width per channel
    localparam int c_TAPS  = 9;    // taps in a 3x3 window
    localparam int c_CH_W  = 8;    // bits per colour channel
    localparam int c_R_LSB = 16;   // R = [23:16]
    localparam int c_G_LSB = 8;    // G = [15:8]
    localparam int c_B_LSB = 0;    // B = [7:0]

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        NORM = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Channel index 0/1/2 -> B/G/R bit offset inside an RGB888 word.
    function automatic int chanLsb(input int ch);
        case (ch)
            0:       return c_B_LSB;
            1:       return c_G_LSB;
            default: return c_R_LSB;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv3x3_rgb_mac_channel.sv
`default_nettype none
// ============================================================================
//  Module     : mac_channel
//  Description: One colour channel of the 3x3 MAC. Signed accumulator with
//               synchronous clear and enable; output is the accumulator
//               arithmetic-shifted right by SHIFT and saturated to 0..255.
//               CONV_ABS_EN: take the magnitude of the shifted value before
//               saturating instead of clamping negatives to zero.
//  Revision   : 1.0  initial release
// ============================================================================
module mac_channel
    import cnn_pkg::*;
#(
    parameter int ACC_W = c_ACC_W,
    parameter int SHIFT = 0
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iClear,
    input  logic              iEn,
    input  logic [7:0]        iPix,
    input  logic signed [7:0] iWeight,
    output logic [7:0]        oSat
);

    localparam logic signed [ACC_W-1:0] c_MAX = ACC_W'(255);

    logic signed [16:0]      w_product;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_shifted;
    logic signed [ACC_W-1:0] w_mag;

    // Pixel is unsigned, so zero-extend it before the signed multiply.
    assign w_product = $signed({1'b0, iPix}) * iWeight;
    assign w_shifted = r_acc >>> SHIFT;

`ifdef CONV_ABS_EN
    assign w_mag = w_shifted[ACC_W-1] ? -w_shifted : w_shifted;
`else
    assign w_mag = w_shifted;
`endif

    // Accumulate one tap per enabled cycle; clear starts a new window.
    always_ff @(posedge iClk) begin
        if (iRst || iClear) begin
            r_acc <= '0;
        end else if (iEn) begin
            r_acc <= r_acc + ACC_W'(w_product);
        end
    end

    // Saturate the normalised value into an unsigned 8-bit channel.
    always_comb begin
        oSat = w_mag[7:0];
        if (w_mag[ACC_W-1]) begin
            oSat = 8'd0;
        end else if (w_mag > c_MAX) begin
            oSat = 8'hFF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv3x3_rgb_mac.sv
`default_nettype none
// ============================================================================
//  Module     : conv3x3_rgb_mac
//  Description: Consumes one 3x3 RGB888 window, runs a 9-cycle sequential
//               multiply-accumulate on R, G and B in parallel with latched
//               signed 8-bit weights, normalises (shift + saturate) and
//               presents one result pixel on a valid/ready output.
//               Optional macro CONV_ABS_EN: negative results are reported
//               as magnitudes instead of clamping to zero.
//  Revision   : 1.0  initial release
// ============================================================================
module conv3x3_rgb_mac
    import cnn_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int SHIFT  = 0,
    parameter int ACC_W  = c_ACC_W
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [DATA_W-1:0]     iWin0,
    input  logic [DATA_W-1:0]     iWin1,
    input  logic [DATA_W-1:0]     iWin2,
    input  logic [DATA_W-1:0]     iWin3,
    input  logic [DATA_W-1:0]     iWin4,
    input  logic [DATA_W-1:0]     iWin5,
    input  logic [DATA_W-1:0]     iWin6,
    input  logic [DATA_W-1:0]     iWin7,
    input  logic [DATA_W-1:0]     iWin8,
    input  logic                  iValid,
    output logic                  oBusy,
    input  logic [8*c_TAPS-1:0]   iWeight,
    output logic [DATA_W-1:0]     oPixel,
    output logic                  oValid,
    input  logic                  iOutReady
);

    state_t              r_state;
    logic [3:0]          r_tap;
    logic [DATA_W-1:0]   r_win [c_TAPS];
    logic [8*c_TAPS-1:0] r_weight;

    logic                w_accept;
    logic                w_macEn;
    logic [DATA_W-1:0]   w_tapPix;
    logic [7:0]          w_tapWeight;
    logic [DATA_W-1:0]   w_sat;

    assign w_accept    = (r_state == IDLE) && iValid && !oBusy;
    assign w_macEn     = (r_state == MAC);
    assign w_tapPix    = r_win[r_tap];
    assign w_tapWeight = r_weight[{r_tap, 3'b000} +: 8];

    // Snapshot window and weights on accept so later input changes are inert.
    always_ff @(posedge iClk) begin
        if (w_accept) begin
            r_win    <= '{iWin0, iWin1, iWin2, iWin3, iWin4,
                          iWin5, iWin6, iWin7, iWin8};
            r_weight <= iWeight;
        end
    end

    // Controller: accept, step through taps, normalise, then hold for ready.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= IDLE;
            r_tap   <= 4'd0;
            oBusy   <= 1'b0;
            oValid  <= 1'b0;
            oPixel  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= MAC;
                        r_tap   <= 4'd0;
                        oBusy   <= 1'b1;
                    end
                end
                MAC: begin
                    if (r_tap == 4'(c_TAPS - 1)) begin
                        r_state <= NORM;
                        r_tap   <= 4'd0;
                    end else begin
                        r_tap   <= r_tap + 4'd1;
                    end
                end
                NORM: begin
                    oPixel  <= w_sat;
                    oValid  <= 1'b1;
                    r_state <= OUT;
                end
                OUT: begin
                    if (iOutReady) begin
                        oValid  <= 1'b0;
                        oBusy   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    oBusy   <= 1'b0;
                    oValid  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar c = 0; c < 3; c++) begin : g_chan
            localparam int c_LSB = chanLsb(c);

            mac_channel #(
                .ACC_W (ACC_W),
                .SHIFT (SHIFT)
            ) u_mac (
                .iClk    (iClk),
                .iRst    (iRst),
                .iClear  (w_accept),
                .iEn     (w_macEn),
                .iPix    (w_tapPix[c_LSB +: c_CH_W]),
                .iWeight (w_tapWeight),
                .oSat    (w_sat[c_LSB +: c_CH_W])
            );
        end
    endgenerate

endmodule
`default_nettype wire
